// File: rtl/fir_feeder_pkg.sv
// Shared types and constants for the FIR sample feeder.
// Optional overflow counter width is used when FIR_FEEDER_OVF_CNT_EN is defined.
package fir_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  localparam int OVF_CNT_W = 16;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer for the FIR feeder.
// Storage, wrapping pointers and occupancy count.
module sample_fifo
  import fir_feeder_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH_IN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [WIDTH_IN-1:0] din,
  input  logic                pop,
  output logic [WIDTH_IN-1:0] head,
  output logic                full,
  output logic                empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH_IN-1:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [AW:0]         count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered samples one at a time into a FIR core and holds each result.
// Define FIR_FEEDER_OVF_CNT_EN to add the saturating ovf_cnt output.
module fir_sample_feeder
  import fir_feeder_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 38
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [WIDTH_IN-1:0]  s_data,
  output logic                 s_ready,
  output logic                 fir_valid,
  output logic [WIDTH_IN-1:0]  fir_data,
  input  logic                 fir_ready,
  input  logic                 fir_done,
  input  logic [WIDTH_OUT-1:0] fir_result,
  output logic                 m_valid,
  output logic [WIDTH_OUT-1:0] m_data,
  input  logic                 m_ready,
  output logic                 busy
`ifdef FIR_FEEDER_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

  state_t state;
  state_t next;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  logic   primed;

  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  assign pop     = (state == ISSUE) && fir_ready;

  sample_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH_IN (WIDTH_IN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .head  (fir_data),
    .full  (full),
    .empty (empty)
  );

  // primed lags !empty by one edge so a fresh sample settles before ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      primed <= 1'b0;
      m_data <= '0;
    end else begin
      state  <= next;
      primed <= !empty;
      if (state == WAIT && fir_done) m_data <= fir_result;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (primed)    next = ISSUE;
      ISSUE: if (fir_ready) next = WAIT;
      WAIT:  if (fir_done)  next = HOLD;
      HOLD:  if (m_ready)   next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign fir_valid = (state == ISSUE);
  assign m_valid   = (state == HOLD);
  assign busy      = (state != IDLE);

`ifdef FIR_FEEDER_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (s_valid && !s_ready && ovf_cnt != '1) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: directed steps plus a random
// phase checked against a queue-based transaction model.
module tb_fir_sample_feeder;

  localparam int DEPTH = 8;
  localparam int WI    = 16;
  localparam int WO    = 38;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [WI-1:0] s_data;
  logic          s_ready;
  logic          fir_valid;
  logic [WI-1:0] fir_data;
  logic          fir_ready;
  logic          fir_done;
  logic [WO-1:0] fir_result;
  logic          m_valid;
  logic [WO-1:0] m_data;
  logic          m_ready;
  logic          busy;
`ifdef FIR_FEEDER_OVF_CNT_EN
  logic [15:0]   ovf_cnt;
`endif

  fir_sample_feeder #(
    .DEPTH     (DEPTH),
    .WIDTH_IN  (WI),
    .WIDTH_OUT (WO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .fir_valid  (fir_valid),
    .fir_data   (fir_data),
    .fir_ready  (fir_ready),
    .fir_done   (fir_done),
    .fir_result (fir_result),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy)
`ifdef FIR_FEEDER_OVF_CNT_EN
    ,
    .ovf_cnt    (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  logic [WI-1:0] q[$];
  logic [WO-1:0] rq[$];
  logic [WO-1:0] last_res;
  bit            popped;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshakes against the model, advance the model.
  task automatic tick();
    bit push;
    chk("s_ready", s_ready, 64'(q.size() < DEPTH));
    push   = s_valid && (q.size() < DEPTH);
    popped = fir_valid && fir_ready;
    if (popped) begin
      chk("pop_nonempty", 64'(q.size() > 0), 1);
      if (q.size() > 0) chk("fir_data", fir_data, q.pop_front());
    end
    if (m_valid && m_ready) begin
      chk("m_expected", 64'(rq.size() > 0), 1);
      if (rq.size() > 0) chk("m_data", m_data, rq.pop_front());
    end
    @(posedge clk);
    if (push) q.push_back(s_data);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!fir_valid && n < budget) begin
      tick();
      n++;
    end
    chk("wait_fir_valid", fir_valid, 1);
  endtask

  task automatic push1(input logic [WI-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic serve(input logic [WO-1:0] r, input int dly);
    wait_valid(20);
    fir_ready = 1'b1;
    tick();
    fir_ready = 1'b0;
    repeat (dly) tick();
    fir_done   = 1'b1;
    fir_result = r;
    rq.push_back(r);
    tick();
    fir_done = 1'b0;
    chk("hold_m_valid", m_valid, 1);
    chk("hold_m_data", m_data, r);
    m_ready = 1'b1;
    tick();
    m_ready  = 1'b0;
    last_res = r;
    chk("release_m_valid", m_valid, 0);
  endtask

  initial begin
    logic [WO-1:0] r;
    int pend;
    int n;

    rst        = 1'b0;
    s_valid    = 1'b1;
    s_data     = 16'h0077;
    fir_ready  = 1'b0;
    fir_done   = 1'b0;
    fir_result = '0;
    m_ready    = 1'b0;
    last_res   = '0;

    // Reset with s_valid held high.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fir_valid", fir_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    s_valid = 1'b0;
    rst     = 1'b1;
    repeat (4) tick();
    chk("rst_nothing_pushed", fir_valid, 0);
    chk("rst_idle", busy, 0);

    // Single sample: latency and one-cycle result.
    fir_ready = 1'b1;
    m_ready   = 1'b1;
    push1(16'h0005);
    chk("lat_t0", fir_valid, 0);
    tick();
    chk("lat_t1", fir_valid, 0);
    tick();
    chk("lat_t2", fir_valid, 1);
    chk("single_fir_data", fir_data, 5);
    tick();
    chk("single_after_pop", fir_valid, 0);
    tick();
    fir_done   = 1'b1;
    fir_result = 38'd25;
    rq.push_back(38'd25);
    tick();
    fir_done = 1'b0;
    chk("single_m_valid", m_valid, 1);
    chk("single_m_data", m_data, 25);
    tick();
    chk("single_m_one_cycle", m_valid, 0);
    m_ready   = 1'b0;
    fir_ready = 1'b0;
    last_res  = 38'd25;

    // Fill to full, drop overflow, drain, wrap pointers.
    for (int i = 1; i <= 8; i++) push1(WI'(i));
    chk("full_s_ready", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 16'd99;
    repeat (4) tick();
    s_valid = 1'b0;
`ifdef FIR_FEEDER_OVF_CNT_EN
    chk("ovf_cnt", ovf_cnt, 4);
`endif
    for (int i = 1; i <= 8; i++) serve(WO'(i * 1000), 1);
    repeat (4) tick();
    chk("drained_fir_valid", fir_valid, 0);
    chk("drained_busy", busy, 0);
    for (int i = 9; i <= 12; i++) push1(WI'(i));
    for (int i = 9; i <= 12; i++) serve(WO'(i * 1000), 0);

    // Backpressure in HOLD while the FIFO keeps filling.
    push1(16'h1234);
    wait_valid(20);
    fir_ready = 1'b1;
    tick();
    fir_ready  = 1'b0;
    r          = 38'h2A_BCDE_F012;
    fir_done   = 1'b1;
    fir_result = r;
    rq.push_back(r);
    tick();
    fir_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = WI'(16'h0100 + i);
      tick();
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, r);
      chk("bp_fir_valid", fir_valid, 0);
    end
    s_valid = 1'b0;
    chk("bp_fifo_full", s_ready, 0);
    m_ready = 1'b1;
    tick();
    m_ready  = 1'b0;
    last_res = r;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      serve(WO'(n + 38'h1_0000_0000), 0);
      n++;
    end

    // Spurious fir_done in IDLE and ISSUE.
    repeat (3) tick();
    fir_done   = 1'b1;
    fir_result = 38'h3F_FFFF_FFFF;
    tick();
    fir_done = 1'b0;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_m_data", m_data, last_res);
    push1(16'hBEEF);
    wait_valid(20);
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    chk("spur_issue_fir_valid", fir_valid, 1);
    chk("spur_issue_m_valid", m_valid, 0);
    chk("spur_issue_m_data", m_data, last_res);
    serve(38'h00_0000_BEEF, 2);

    // Reset while in WAIT with 3 samples queued.
    for (int i = 0; i < 4; i++) push1(WI'(16'h0A00 + i));
    wait_valid(20);
    fir_ready = 1'b1;
    tick();
    fir_ready = 1'b0;
    chk("mid_in_wait", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_s_ready", s_ready, 1);
    chk("mid_fir_valid", fir_valid, 0);
    chk("mid_m_valid", m_valid, 0);
    chk("mid_m_data", m_data, 0);
    q.delete();
    rq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) tick();
    chk("mid_no_fir_valid", fir_valid, 0);
    push1(16'h4242);
    serve(38'h00_0004_2424, 1);

    // Random traffic against the transaction model.
    pend = -1;
    for (int c = 0; c < 600; c++) begin
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = WI'($urandom);
      fir_ready = 1'($urandom_range(0, 1));
      m_ready   = 1'($urandom_range(0, 1));
      if (pend == 0) begin
        r          = WO'({$urandom, $urandom});
        fir_done   = 1'b1;
        fir_result = r;
        rq.push_back(r);
        pend = -1;
      end else begin
        fir_done = 1'b0;
        if (pend > 0) pend--;
      end
      tick();
      if (popped) pend = $urandom_range(0, 3);
    end
    s_valid   = 1'b0;
    fir_ready = 1'b1;
    m_ready   = 1'b1;
    n = 0;
    while ((q.size() > 0 || busy || pend >= 0) && n < 300) begin
      if (pend == 0) begin
        r          = WO'({$urandom, $urandom});
        fir_done   = 1'b1;
        fir_result = r;
        rq.push_back(r);
        pend = -1;
      end else begin
        fir_done = 1'b0;
        if (pend > 0) pend--;
      end
      tick();
      if (popped) pend = $urandom_range(0, 3);
      n++;
    end
    fir_done = 1'b0;
    tick();
    chk("rand_drain_busy", busy, 0);
    chk("rand_results_left", 64'(rq.size()), 0);
    chk("rand_samples_left", 64'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
